// File: rtl/sram_responder_pkg.sv
// Shared types and default sizing for the SRAM target model.
// Request decoding lives here so the FSM and any future monitors agree on what counts as illegal.
package sram_pkg;

    localparam int DEF_ADDR_BITS      = 16;
    localparam int DEF_DATA_BITS      = 32;
    localparam int DEF_MEM_DEPTH_BITS = 8;
    localparam int DEF_LATENCY        = 12;
    localparam int DEF_CNT_BITS       = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        REQ_READ,
        REQ_WRITE,
        REQ_ILLEGAL
    } req_mode_t;

    // Exactly one enable must be set and the word must exist in the implemented array.
    function automatic req_mode_t decode_req(input logic rd, input logic wr, input logic in_range);
        if (!in_range || (rd == wr)) begin
            return REQ_ILLEGAL;
        end else if (rd) begin
            return REQ_READ;
        end else begin
            return REQ_WRITE;
        end
    endfunction

endpackage

// File: rtl/sram_responder_flex_counter.sv
// Clearable up-counter used as the access latency timer.
// rollover_flag marks the enabled cycle whose increment reaches rollover_val; the count then wraps to 0.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] count_q;
    logic [NUM_CNT_BITS-1:0] count_d;
    logic [NUM_CNT_BITS-1:0] count_inc;

    assign count_inc = count_q + NUM_CNT_BITS'(1);

    always_comb begin
        count_d       = count_q;
        rollover_flag = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            if (count_inc == rollover_val) begin
                count_d       = '0;
                rollover_flag = 1'b1;
            end else begin
                count_d = count_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sram_responder.sv
// Synthesizable SRAM target: captures a cs-qualified request, waits a fixed latency,
// then commits the write or returns read data and pulses ack (with err for illegal requests).
module sram_responder
    import sram_pkg::*;
#(
    parameter int ADDR_BITS      = sram_pkg::DEF_ADDR_BITS,
    parameter int DATA_BITS      = sram_pkg::DEF_DATA_BITS,
    parameter int MEM_DEPTH_BITS = sram_pkg::DEF_MEM_DEPTH_BITS,
    parameter int LATENCY        = sram_pkg::DEF_LATENCY,
    parameter int CNT_BITS       = sram_pkg::DEF_CNT_BITS
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 cs,
    input  logic                 read_enable,
    input  logic                 write_enable,
    input  logic [0:ADDR_BITS-1] address,
    input  logic [DATA_BITS-1:0] w_data,
    output logic [DATA_BITS-1:0] r_data,
    output logic                 ack,
    output logic                 err,
    output logic                 busy
);

    localparam int                  MEM_WORDS = 1 << MEM_DEPTH_BITS;
    localparam logic [CNT_BITS-1:0] ROLLOVER  = CNT_BITS'(LATENCY - 1);

    state_t                    state_q, state_d;
    req_mode_t                 mode_q, mode_d;
    logic [MEM_DEPTH_BITS-1:0] idx_q, idx_d;
    logic [DATA_BITS-1:0]      wdata_q, wdata_d;
    logic [DATA_BITS-1:0]      r_data_q, r_data_d;
    logic [DATA_BITS-1:0]      mem_q [MEM_WORDS];

    logic [ADDR_BITS-1:0]      addr_value;
    logic                      addr_in_range;
    req_mode_t                 live_mode;
    logic                      capture;
    logic                      cnt_clear;
    logic                      cnt_enable;
    logic                      wait_done;
    logic                      enter_resp;
    req_mode_t                 commit_mode;
    logic [MEM_DEPTH_BITS-1:0] commit_idx;
    logic [DATA_BITS-1:0]      commit_wdata;
    logic                      mem_we;

    assign addr_value    = address;
    assign addr_in_range = (addr_value < ADDR_BITS'(MEM_WORDS));
    assign live_mode     = decode_req(read_enable, write_enable, addr_in_range);

    flex_counter #(
        .NUM_CNT_BITS(CNT_BITS)
    ) u_latency_timer (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (cnt_clear),
        .count_enable (cnt_enable),
        .rollover_val (ROLLOVER),
        .rollover_flag(wait_done)
    );

    // Requests are only accepted outside WAIT; cs while counting is simply ignored.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        capture    = 1'b0;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                if (cs) begin
                    capture   = 1'b1;
                    cnt_clear = 1'b1;
                    mode_d    = live_mode;
                    idx_d     = addr_value[MEM_DEPTH_BITS-1:0];
                    wdata_d   = w_data;
                    state_d   = (LATENCY == 1) ? RESP : WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                cnt_enable = 1'b1;
                if (wait_done) begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // With LATENCY=1 the capture edge is also the commit edge, so commit from the live request.
    always_comb begin
        enter_resp   = (state_d == RESP);
        commit_mode  = capture ? live_mode : mode_q;
        commit_idx   = capture ? addr_value[MEM_DEPTH_BITS-1:0] : idx_q;
        commit_wdata = capture ? w_data : wdata_q;
        mem_we       = enter_resp && (commit_mode == REQ_WRITE);
        r_data_d     = r_data_q;
        if (enter_resp) begin
            if (commit_mode == REQ_READ) begin
                r_data_d = mem_q[commit_idx];
            end else if (commit_mode == REQ_ILLEGAL) begin
                r_data_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            mode_q   <= REQ_ILLEGAL;
            idx_q    <= '0;
            wdata_q  <= '0;
            r_data_q <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            r_data_q <= r_data_d;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[commit_idx] <= commit_wdata;
        end
    end

    assign r_data = r_data_q;
    assign ack    = (state_q == RESP);
    assign err    = (state_q == RESP) && (mode_q == REQ_ILLEGAL);
    assign busy   = (state_q == WAIT);

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder: a LATENCY=12 instance checked through an expected-response queue,
// plus a LATENCY=1 instance exercised directly.
module tb_sram_responder;

    localparam int LAT = 12;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        cs, rd, wr;
    logic [0:15] address;
    logic [31:0] w_data, r_data;
    logic        ack, err, busy;

    logic        cs1, rd1, wr1;
    logic [0:15] address1;
    logic [31:0] w_data1, r_data1;
    logic        ack1, err1, busy1;

    typedef struct {
        int          ack_cycle;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_mem [256];
    logic [31:0] model_rdata;
    int          cycle = 0;
    int          vectors = 0;
    int          miscompares = 0;

    sram_responder #(.LATENCY(LAT), .CNT_BITS(4)) dut (
        .clk(clk), .n_rst(n_rst), .cs(cs), .read_enable(rd), .write_enable(wr),
        .address(address), .w_data(w_data), .r_data(r_data), .ack(ack), .err(err), .busy(busy)
    );

    sram_responder #(.LATENCY(1), .CNT_BITS(4)) dut1 (
        .clk(clk), .n_rst(n_rst), .cs(cs1), .read_enable(rd1), .write_enable(wr1),
        .address(address1), .w_data(w_data1), .r_data(r_data1), .ack(ack1), .err(err1), .busy(busy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
        vectors++;
        if (got !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, expected, cycle);
        end
    endtask

    task automatic resetModel();
        for (int i = 0; i < 256; i++) model_mem[i] = '0;
        model_rdata = '0;
        sb.delete();
    endtask

    // Called at a negedge: drives one cs cycle and, if the DUT should accept it, queues the expected response.
    task automatic applyStimulus(input logic rd_i, input logic wr_i, input logic [15:0] addr_i,
                                 input logic [31:0] data_i, input bit accept);
        exp_t e;
        logic illegal;
        cs      = 1'b1;
        rd      = rd_i;
        wr      = wr_i;
        address = addr_i;
        w_data  = data_i;
        if (accept) begin
            illegal = (rd_i == wr_i) || (addr_i >= 16'h0100);
            if (illegal) model_rdata = '0;
            else if (rd_i) model_rdata = model_mem[addr_i[7:0]];
            else model_mem[addr_i[7:0]] = data_i;
            e.ack_cycle = cycle + LAT;
            e.err       = illegal;
            e.rdata     = model_rdata;
            sb.push_back(e);
        end
        @(negedge clk);
        cs = 1'b0;
        rd = 1'b0;
        wr = 1'b0;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 4 * LAT && sb.size() > 0; i++) @(negedge clk);
        checkOutput("drain", sb.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic waitAck();
        int i;
        for (i = 0; i < 4 * LAT && !ack; i++) @(negedge clk);
        checkOutput("ack_seen", ack, 1'b1);
    endtask

    always @(negedge clk) begin
        if (n_rst && ack) begin
            checkOutput("ack_expected", (sb.size() > 0), 1'b1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("ack_latency", cycle, e.ack_cycle);
                checkOutput("err", err, e.err);
                checkOutput("r_data", r_data, e.rdata);
                checkOutput("busy_at_ack", busy, 1'b0);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_rst = 1'b0;
        cs = 1'b0; rd = 1'b0; wr = 1'b0; address = '0; w_data = '0;
        cs1 = 1'b0; rd1 = 1'b0; wr1 = 1'b0; address1 = '0; w_data1 = '0;
        resetModel();
        repeat (2) @(negedge clk);
        n_rst = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("idle_r_data", r_data, 32'h0);
            checkOutput("idle_ack", ack, 1'b0);
            checkOutput("idle_err", err, 1'b0);
            checkOutput("idle_busy", busy, 1'b0);
        end

        applyStimulus(1'b0, 1'b1, 16'h0005, 32'hDEADBEEF, 1'b1);
        checkOutput("busy_in_wait", busy, 1'b1);
        waitDrain();
        applyStimulus(1'b1, 1'b0, 16'h0005, 32'h0, 1'b1);
        waitDrain();

        applyStimulus(1'b0, 1'b1, 16'h0006, 32'h12345678, 1'b1);
        waitAck();
        applyStimulus(1'b1, 1'b0, 16'h0005, 32'h0, 1'b1);
        waitDrain();
        applyStimulus(1'b1, 1'b0, 16'h0006, 32'h0, 1'b1);
        waitDrain();

        applyStimulus(1'b1, 1'b1, 16'h0005, 32'hFFFFFFFF, 1'b1);
        waitDrain();
        applyStimulus(1'b1, 1'b0, 16'h0005, 32'h0, 1'b1);
        waitDrain();
        applyStimulus(1'b1, 1'b0, 16'h0100, 32'h0, 1'b1);
        waitDrain();
        applyStimulus(1'b0, 1'b0, 16'h0006, 32'h0, 1'b1);
        waitDrain();

        applyStimulus(1'b0, 1'b1, 16'h0007, 32'h11111111, 1'b1);
        repeat (3) @(negedge clk);
        applyStimulus(1'b1, 1'b0, 16'h0006, 32'h0, 1'b0);
        waitDrain();
        applyStimulus(1'b1, 1'b0, 16'h0007, 32'h0, 1'b1);
        waitDrain();

        applyStimulus(1'b0, 1'b1, 16'h0010, 32'hCAFEF00D, 1'b0);
        repeat (5) @(negedge clk);
        n_rst = 1'b0;
        resetModel();
        @(negedge clk);
        checkOutput("rst_ack", ack, 1'b0);
        checkOutput("rst_r_data", r_data, 32'h0);
        n_rst = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_busy", busy, 1'b0);
        repeat (2 * LAT) @(negedge clk);
        applyStimulus(1'b1, 1'b0, 16'h0010, 32'h0, 1'b1);
        waitDrain();

        cs1 = 1'b1; rd1 = 1'b1; wr1 = 1'b0; address1 = 16'h0000;
        @(negedge clk);
        checkOutput("lat1_ack", ack1, 1'b1);
        checkOutput("lat1_err", err1, 1'b0);
        checkOutput("lat1_busy", busy1, 1'b0);
        checkOutput("lat1_r_data", r_data1, 32'h0);
        rd1 = 1'b0; wr1 = 1'b1; address1 = 16'h0003; w_data1 = 32'hA5A55A5A;
        @(negedge clk);
        checkOutput("lat1_wr_ack", ack1, 1'b1);
        checkOutput("lat1_wr_busy", busy1, 1'b0);
        rd1 = 1'b1; wr1 = 1'b0;
        @(negedge clk);
        checkOutput("lat1_rd_ack", ack1, 1'b1);
        checkOutput("lat1_rd_data", r_data1, 32'hA5A55A5A);
        checkOutput("lat1_rd_busy", busy1, 1'b0);
        cs1 = 1'b0; rd1 = 1'b0;
        @(negedge clk);
        checkOutput("lat1_idle_ack", ack1, 1'b0);
        checkOutput("lat1_idle_busy", busy1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
